// File: rtl/n_chan_shadow_reg_if.sv
// n_chan_shadow_reg_if: bus-side write/commit/readback bundle
// for the double-buffered control register bank
interface n_chan_shadow_reg_if #(
   parameter int N = 8,
   parameter int C = 4
);
   localparam int NB = (N + 7) / 8;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [NB-1:0] wr_be;
   logic [N-1:0]  wr_data;
   logic          commit;
   logic [C-1:0]  commit_mask;
   logic          rd_req;
   logic [CW-1:0] rd_ch;
   logic          rd_shadow;
   logic [N-1:0]  rd_data;
   logic          rd_valid;
   logic [C-1:0]  pending;

   modport master (
      output wr_en, wr_ch, wr_be, wr_data,
      output commit, commit_mask,
      output rd_req, rd_ch, rd_shadow,
      input  rd_data, rd_valid, pending
   );

   modport slave (
      input  wr_en, wr_ch, wr_be, wr_data,
      input  commit, commit_mask,
      input  rd_req, rd_ch, rd_shadow,
      output rd_data, rd_valid, pending
   );
endinterface

// File: rtl/n_chan_shadow_reg.sv
// n_chan_shadow_reg: C double-buffered N-bit control registers with
// byte-writable shadows, atomic masked commit and registered readback
module n_chan_shadow_reg #(
   parameter int N = 8,
   parameter int C = 4,
   parameter logic [N-1:0] V = '0,
   parameter bit AUTO_COMMIT = 1'b0
) (
   input  logic clk,
   input  logic clr,
   n_chan_shadow_reg_if.slave bus,
   output logic [C*N-1:0] active_flat
);
   logic [N-1:0] shadow [C];
   logic [N-1:0] active [C];
   logic [C-1:0] pend_q;
   logic [N-1:0] rd_q;
   logic         rd_v_q;
   logic [N-1:0] lane_m;
   logic [N-1:0] rd_sel;
   logic         wr_hit;
   logic         rd_hit;

   always_comb begin
      lane_m = '0;
      for (int i = 0; i < N; i++) begin
         lane_m[i] = bus.wr_be[i>>3];
      end
   end

   // out-of-range channels only exist when C is not a power of two
   assign wr_hit = bus.wr_en && (32'(bus.wr_ch) < C)
                   && (|bus.wr_be);
   assign rd_hit = 32'(bus.rd_ch) < C;

   always_comb begin
      rd_sel = '0;
      if (rd_hit) begin
         rd_sel = bus.rd_shadow ? shadow[bus.rd_ch]
                                : active[bus.rd_ch];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int c = 0; c < C; c++) begin
            shadow[c] <= V;
            active[c] <= V;
         end
         pend_q <= '0;
         rd_q   <= '0;
         rd_v_q <= 1'b0;
      end else begin
         rd_v_q <= bus.rd_req;
         if (bus.rd_req) begin
            rd_q <= rd_sel;
         end
         for (int c = 0; c < C; c++) begin
            if (bus.commit && bus.commit_mask[c]) begin
               active[c] <= shadow[c];
               pend_q[c] <= 1'b0;
            end
            // later assignment: a same-cycle write beats the commit clear
            if (wr_hit && (32'(bus.wr_ch) == 32'(c))) begin
               shadow[c] <= (shadow[c] & ~lane_m)
                            | (bus.wr_data & lane_m);
               if (AUTO_COMMIT) begin
                  active[c] <= (active[c] & ~lane_m)
                               | (bus.wr_data & lane_m);
               end else begin
                  pend_q[c] <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.rd_data  = rd_q;
   assign bus.rd_valid = rd_v_q;
   assign bus.pending  = pend_q;

   always_comb begin
      active_flat = '0;
      for (int c = 0; c < C; c++) begin
         active_flat[c*N +: N] = active[c];
      end
   end
endmodule

// File: tb/tb_n_chan_shadow_reg.sv
// tb_n_chan_shadow_reg: three configurations driven in lockstep,
// checked every cycle against a per-instance array model
module tb_n_chan_shadow_reg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        s_clr;
   logic        s_wr_en;
   logic [1:0]  s_wr_ch;
   logic [1:0]  s_wr_be;
   logic [15:0] s_wr_data;
   logic        s_commit;
   logic [3:0]  s_mask;
   logic        s_rd_req;
   logic [1:0]  s_rd_ch;
   logic        s_rd_sh;

   logic [63:0] fa;
   logic [35:0] fb;
   logic [63:0] fc;

   n_chan_shadow_reg_if #(.N(16), .C(4)) ia ();
   n_chan_shadow_reg_if #(.N(12), .C(3)) ib ();
   n_chan_shadow_reg_if #(.N(16), .C(4)) ic ();

   assign ia.wr_en = s_wr_en;
   assign ia.wr_ch = s_wr_ch;
   assign ia.wr_be = s_wr_be;
   assign ia.wr_data = s_wr_data;
   assign ia.commit = s_commit;
   assign ia.commit_mask = s_mask;
   assign ia.rd_req = s_rd_req;
   assign ia.rd_ch = s_rd_ch;
   assign ia.rd_shadow = s_rd_sh;

   assign ib.wr_en = s_wr_en;
   assign ib.wr_ch = s_wr_ch;
   assign ib.wr_be = s_wr_be;
   assign ib.wr_data = s_wr_data[11:0];
   assign ib.commit = s_commit;
   assign ib.commit_mask = s_mask[2:0];
   assign ib.rd_req = s_rd_req;
   assign ib.rd_ch = s_rd_ch;
   assign ib.rd_shadow = s_rd_sh;

   assign ic.wr_en = s_wr_en;
   assign ic.wr_ch = s_wr_ch;
   assign ic.wr_be = s_wr_be;
   assign ic.wr_data = s_wr_data;
   assign ic.commit = s_commit;
   assign ic.commit_mask = s_mask;
   assign ic.rd_req = s_rd_req;
   assign ic.rd_ch = s_rd_ch;
   assign ic.rd_shadow = s_rd_sh;

   n_chan_shadow_reg #(
      .N(16), .C(4), .V(16'h00A5), .AUTO_COMMIT(1'b0)
   ) ua (.clk(clk), .clr(s_clr), .bus(ia.slave), .active_flat(fa));

   n_chan_shadow_reg #(
      .N(12), .C(3), .V(12'h5A3), .AUTO_COMMIT(1'b0)
   ) ub (.clk(clk), .clr(s_clr), .bus(ib.slave), .active_flat(fb));

   n_chan_shadow_reg #(
      .N(16), .C(4), .V(16'h0F0F), .AUTO_COMMIT(1'b1)
   ) uc (.clk(clk), .clr(s_clr), .bus(ic.slave), .active_flat(fc));

   int pn [3] = '{16, 12, 16};
   int pc [3] = '{4, 3, 4};
   bit pac [3] = '{1'b0, 1'b0, 1'b1};
   logic [15:0] pv [3] = '{16'h00A5, 16'h05A3, 16'h0F0F};

   logic [15:0] msh [3][4];
   logic [15:0] mac [3][4];
   logic [3:0]  mpend [3];
   logic [15:0] mrd [3];
   logic        mrv [3];

   int total = 0;
   int bad = 0;

   task automatic check(string nm, logic [63:0] act,
                        logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         logic [15:0] nm;
         logic [15:0] bm;
         logic [15:0] so [4];
         logic [15:0] ao [4];
         nm = (pn[k] == 16) ? 16'hFFFF : 16'h0FFF;
         if (s_clr) begin
            for (int ch = 0; ch < 4; ch++) begin
               msh[k][ch] = pv[k];
               mac[k][ch] = pv[k];
            end
            mpend[k] = '0;
            mrd[k] = '0;
            mrv[k] = 1'b0;
         end else begin
            so = msh[k];
            ao = mac[k];
            mrv[k] = s_rd_req;
            if (s_rd_req) begin
               if (int'(s_rd_ch) < pc[k])
                  mrd[k] = s_rd_sh ? so[s_rd_ch] : ao[s_rd_ch];
               else
                  mrd[k] = '0;
            end
            if (s_commit) begin
               for (int ch = 0; ch < pc[k]; ch++) begin
                  if (s_mask[ch]) begin
                     mac[k][ch] = so[ch];
                     mpend[k][ch] = 1'b0;
                  end
               end
            end
            if (s_wr_en && int'(s_wr_ch) < pc[k] && s_wr_be != 0) begin
               bm = {{8{s_wr_be[1]}}, {8{s_wr_be[0]}}} & nm;
               msh[k][s_wr_ch] = (so[s_wr_ch] & ~bm) | (s_wr_data & bm);
               if (pac[k])
                  mac[k][s_wr_ch] = (mac[k][s_wr_ch] & ~bm)
                                    | (s_wr_data & bm);
               else
                  mpend[k][s_wr_ch] = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [15:0] d_rd [3];
      logic        d_rv [3];
      logic [3:0]  d_pd [3];
      logic [15:0] d_act [3][4];
      d_rd[0] = ia.rd_data;
      d_rd[1] = {4'h0, ib.rd_data};
      d_rd[2] = ic.rd_data;
      d_rv[0] = ia.rd_valid;
      d_rv[1] = ib.rd_valid;
      d_rv[2] = ic.rd_valid;
      d_pd[0] = ia.pending;
      d_pd[1] = {1'b0, ib.pending};
      d_pd[2] = ic.pending;
      for (int ch = 0; ch < 4; ch++) begin
         d_act[0][ch] = fa[ch*16 +: 16];
         d_act[2][ch] = fc[ch*16 +: 16];
         d_act[1][ch] = (ch < 3) ? {4'h0, fb[ch*12 +: 12]} : 16'h0;
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("k%0d rd_data", k), 64'(d_rd[k]), 64'(mrd[k]));
         check($sformatf("k%0d rd_valid", k), 64'(d_rv[k]), 64'(mrv[k]));
         check($sformatf("k%0d pending", k), 64'(d_pd[k]), 64'(mpend[k]));
         for (int ch = 0; ch < pc[k]; ch++)
            check($sformatf("k%0d active%0d", k, ch),
                  64'(d_act[k][ch]), 64'(mac[k][ch]));
      end
   endtask

   task automatic idle();
      s_clr = 1'b0;
      s_wr_en = 1'b0;
      s_wr_ch = '0;
      s_wr_be = '0;
      s_wr_data = '0;
      s_commit = 1'b0;
      s_mask = '0;
      s_rd_req = 1'b0;
      s_rd_ch = '0;
      s_rd_sh = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic wr(logic [1:0] ch, logic [1:0] be, logic [15:0] d);
      s_wr_en = 1'b1;
      s_wr_ch = ch;
      s_wr_be = be;
      s_wr_data = d;
   endtask

   task automatic rd(logic [1:0] ch, logic sh);
      s_rd_req = 1'b1;
      s_rd_ch = ch;
      s_rd_sh = sh;
   endtask

   initial begin
      idle();
      s_clr = 1'b1;
      cyc();
      cyc();
      s_clr = 1'b0;

      // reset values through both readback sources
      for (int ch = 0; ch < 4; ch++) begin
         for (int sh = 0; sh < 2; sh++) begin
            idle();
            rd(2'(ch), sh[0]);
            cyc();
            check("t1 rd", 64'(ia.rd_data), 64'h00A5);
            check("t1 rv", 64'(ia.rd_valid), 64'h1);
         end
      end
      check("t1 model rd", 64'(mrd[0]), 64'h00A5);
      idle();
      cyc();
      check("t1 rv drop", 64'(ia.rd_valid), 64'h0);
      check("t1 pend", 64'(ia.pending), 64'h0);
      check("t1 flat", fa, {4{16'h00A5}});

      // byte-lane writes then commit
      wr(2'd2, 2'b01, 16'h1234);
      cyc();
      wr(2'd2, 2'b10, 16'hABFF);
      cyc();
      idle();
      rd(2'd2, 1'b1);
      cyc();
      check("t2 shadow", 64'(ia.rd_data), 64'hAB34);
      check("t2 model sh", 64'(msh[0][2]), 64'hAB34);
      check("t2 pend", 64'(ia.pending), 64'h4);
      check("t2 act old", 64'(fa[47:32]), 64'h00A5);
      idle();
      s_commit = 1'b1;
      s_mask = 4'b0100;
      cyc();
      check("t2 act new", 64'(fa[47:32]), 64'hAB34);
      check("t2 pend clr", 64'(ia.pending), 64'h0);

      // write and commit same channel, same cycle
      idle();
      wr(2'd1, 2'b11, 16'h5555);
      s_commit = 1'b1;
      s_mask = 4'b0010;
      cyc();
      check("t3 act", 64'(fa[31:16]), 64'h00A5);
      check("t3 pend", 64'(ia.pending), 64'h2);
      idle();
      rd(2'd1, 1'b1);
      s_commit = 1'b1;
      s_mask = 4'b0010;
      cyc();
      check("t3 shadow", 64'(ia.rd_data), 64'h5555);
      check("t3 act2", 64'(fa[31:16]), 64'h5555);

      // two-channel atomic commit, then clr beats a write
      idle();
      wr(2'd0, 2'b11, 16'h1111);
      cyc();
      wr(2'd3, 2'b11, 16'h3333);
      cyc();
      idle();
      s_commit = 1'b1;
      s_mask = 4'b1001;
      cyc();
      check("t4 flat", fa, {16'h3333, 16'hAB34, 16'h5555, 16'h1111});
      idle();
      s_clr = 1'b1;
      wr(2'd3, 2'b11, 16'h7777);
      cyc();
      idle();
      rd(2'd3, 1'b1);
      cyc();
      check("t4 clr flat", fa, {4{16'h00A5}});
      check("t4 clr sh3", 64'(ia.rd_data), 64'h00A5);
      check("t4 clr pend", 64'(ia.pending), 64'h0);

      // C=3, N=12: invalid channel and truncated top lane
      idle();
      wr(2'd3, 2'b11, 16'h0FFF);
      cyc();
      check("t5 flat", 64'(fb), 64'({3{12'h5A3}}));
      check("t5 pend", 64'(ib.pending), 64'h0);
      idle();
      rd(2'd3, 1'b0);
      cyc();
      check("t5 rd oor", 64'(ib.rd_data), 64'h0);
      check("t5 rv oor", 64'(ib.rd_valid), 64'h1);
      idle();
      wr(2'd0, 2'b10, 16'h0F00);
      cyc();
      check("t5 rv drop", 64'(ib.rd_valid), 64'h0);
      idle();
      rd(2'd0, 1'b1);
      cyc();
      check("t5 top lane", 64'(ib.rd_data), 64'hFA3);
      check("t5 model top", 64'(msh[1][0]), 64'hFA3);

      // transparent mode instance
      idle();
      s_clr = 1'b1;
      cyc();
      idle();
      wr(2'd1, 2'b11, 16'hC0DE);
      rd(2'd1, 1'b0);
      cyc();
      check("t6 rd old", 64'(ic.rd_data), 64'h0F0F);
      check("t6 act", 64'(fc[31:16]), 64'hC0DE);
      check("t6 pend", 64'(ic.pending), 64'h0);
      idle();
      rd(2'd1, 1'b0);
      cyc();
      check("t6 rd new", 64'(ic.rd_data), 64'hC0DE);

      for (int i = 0; i < 3000; i++) begin
         s_clr = ($urandom_range(0, 63) == 0);
         s_wr_en = $urandom_range(0, 1) == 1;
         s_wr_ch = 2'($urandom);
         s_wr_be = 2'($urandom);
         s_wr_data = 16'($urandom);
         s_commit = ($urandom_range(0, 3) == 0);
         s_mask = 4'($urandom);
         s_rd_req = $urandom_range(0, 1) == 1;
         s_rd_ch = 2'($urandom);
         s_rd_sh = $urandom_range(0, 1) == 1;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
